// File: rtl/spi_cfg_sequencer.sv
// Configuration sequencer for the shared ADC1/PLL SPI engine: walks a table or
// forwards a single host write, pacing transfers by counting cycles.
module spi_cfg_sequencer #(
  parameter int NUM_WORDS    = 16,
  parameter int ADDR_W       = 6,
  parameter int XFER_CYCLES  = 24,
  parameter int GAP_CYCLES   = 4,
  parameter int DELAY_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] tbl_addr,
  input  logic [25:0]       tbl_data,
  input  logic              wr_req,
  input  logic              wr_target,
  input  logic [23:0]       wr_data,
  output logic              wr_ack,
  output logic              send_adc,
  output logic              send_pll,
  output logic [23:0]       data_adc,
  output logic [23:0]       data_pll,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(XFER_CYCLES + GAP_CYCLES + DELAY_CYCLES + 1);
  localparam logic [CNT_W-1:0]  XFER_LEN  = CNT_W'(XFER_CYCLES);
  localparam logic [CNT_W-1:0]  GAP_LEN   = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0]  DELAY_LEN = CNT_W'(GAP_CYCLES + DELAY_CYCLES);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_XFER, S_GAP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_index;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [CNT_W-1:0]  w_gap_len;
  logic              r_target;
  logic              r_flag;
  logic              r_manual;
  logic              r_done;
  logic [23:0]       r_data_adc;
  logic [23:0]       r_data_pll;
  logic              w_start_acc;
  logic              w_wr_acc;
  logic              w_cnt_last;
  logic              w_seq_end;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_gap_len = r_flag ? DELAY_LEN : GAP_LEN;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Counter expiry compares the incremented count so a zero length still
  // spends exactly one cycle in the state instead of wrapping.
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_wr_acc    = 1'b0;
    w_cnt_last  = 1'b0;
    w_seq_end   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_state_nxt = S_FETCH;
        end else if (wr_req) begin
          w_wr_acc    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_FETCH: w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_XFER;
      S_XFER: begin
        if (w_cnt_inc >= XFER_LEN) begin
          w_cnt_last  = 1'b1;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (w_cnt_inc >= w_gap_len) begin
          w_cnt_last = 1'b1;
          if (r_manual) begin
            w_state_nxt = S_IDLE;
          end else if (r_index == LAST_IDX) begin
            w_seq_end   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_FETCH;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Payloads land in the per-target data registers on entry to ISSUE, so the
  // data is already stable during the one-cycle send pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_index    <= '0;
      r_cnt      <= '0;
      r_target   <= 1'b0;
      r_flag     <= 1'b0;
      r_manual   <= 1'b0;
      r_done     <= 1'b0;
      r_data_adc <= '0;
      r_data_pll <= '0;
    end else begin
      if (r_state == S_XFER || r_state == S_GAP)
        r_cnt <= w_cnt_last ? '0 : w_cnt_inc;
      else
        r_cnt <= '0;

      if (w_start_acc) begin
        r_index  <= '0;
        r_done   <= 1'b0;
        r_manual <= 1'b0;
      end else if (r_state == S_GAP && w_cnt_last && !r_manual && !w_seq_end) begin
        r_index <= r_index + 1'b1;
      end

      if (w_seq_end) r_done <= 1'b1;

      if (w_wr_acc) begin
        r_manual <= 1'b1;
        r_target <= wr_target;
        r_flag   <= 1'b0;
        if (wr_target) r_data_pll <= wr_data;
        else           r_data_adc <= wr_data;
      end else if (r_state == S_LOAD) begin
        r_target <= tbl_data[25];
        r_flag   <= tbl_data[24];
        if (tbl_data[25]) r_data_pll <= tbl_data[23:0];
        else              r_data_adc <= tbl_data[23:0];
      end
    end
  end

  assign tbl_addr = r_index;
  assign wr_ack   = w_wr_acc;
  assign send_adc = (r_state == S_ISSUE) && !r_target;
  assign send_pll = (r_state == S_ISSUE) &&  r_target;
  assign data_adc = r_data_adc;
  assign data_pll = r_data_pll;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Scoreboard bench for spi_cfg_sequencer: stimulus tasks predict send/ack
// events with absolute cycle stamps, a negedge monitor pops and compares them.
module tb_spi_cfg_sequencer;

  localparam int NW = 3;
  localparam int AW = 6;
  localparam int XC = 24;
  localparam int GC = 4;
  localparam int DC = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] tbl_addr;
  logic [25:0]   tbl_data;
  logic          wr_req;
  logic          wr_target;
  logic [23:0]   wr_data;
  logic          wr_ack;
  logic          send_adc;
  logic          send_pll;
  logic [23:0]   data_adc;
  logic [23:0]   data_pll;
  logic          busy;
  logic          done;

  spi_cfg_sequencer #(
    .NUM_WORDS(NW), .ADDR_W(AW), .XFER_CYCLES(XC),
    .GAP_CYCLES(GC), .DELAY_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .wr_req(wr_req), .wr_target(wr_target),
    .wr_data(wr_data), .wr_ack(wr_ack), .send_adc(send_adc),
    .send_pll(send_pll), .data_adc(data_adc), .data_pll(data_pll),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [25:0] mem [0:63];
  always @(posedge clk) tbl_data <= mem[tbl_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        tgt;
    int          at;
    logic [23:0] adc;
    logic [23:0] pll;
  } ev_t;

  ev_t exp_q[$];
  int  ack_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  logic [23:0] m_adc = '0;
  logic [23:0] m_pll = '0;
  logic        m_done = 1'b0;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic void push_ev(input logic tgt, input logic [23:0] d, input int at);
    ev_t e;
    if (tgt) m_pll = d;
    else     m_adc = d;
    e.tgt = tgt;
    e.at  = at;
    e.adc = m_adc;
    e.pll = m_pll;
    exp_q.push_back(e);
  endfunction

  ev_t me;
  always @(negedge clk) begin
    if (send_adc && send_pll) begin
      chk("both_sends", 1, 0);
    end else if (send_adc || send_pll) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_send", 1, 0);
      end else begin
        me = exp_q.pop_front();
        chk("send_target", send_pll, me.tgt);
        chk("send_cycle", cyc, me.at);
        chk("data_adc", data_adc, me.adc);
        chk("data_pll", data_pll, me.pll);
      end
    end
    if (wr_ack) begin
      if (ack_q.size() == 0) chk("unexpected_ack", 1, 0);
      else                   chk("ack_cycle", cyc, ack_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (busy && n < 5000);
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  // mode 0: plain run, 1: start/wr_req pulsed mid-XFER, 2: reset during the
  // last entry's XFER, 3: wr_req raised together with start and held.
  task automatic run_table(input int mode, input bit fill);
    int          c, iss, fin, iss0;
    logic        wt;
    logic [23:0] wd;
    if (fill)
      for (int k = 0; k < NW; k++)
        mem[k] = {1'($urandom), 1'($urandom_range(0, 3) == 0), 24'($urandom)};
    c    = cyc;
    iss  = c + 3;
    iss0 = iss;
    fin  = 0;
    for (int k = 0; k < NW; k++) begin
      push_ev(mem[k][25], mem[k][23:0], iss);
      fin = iss + 1 + XC + GC + (mem[k][24] ? DC : 0);
      if (k < NW - 1) iss = fin + 2;
    end
    wt = 1'($urandom);
    wd = 24'($urandom);
    if (mode == 3) begin
      ack_q.push_back(fin);
      push_ev(wt, wd, fin + 1);
    end
    start = 1'b1;
    if (mode == 3) begin
      wr_req    = 1'b1;
      wr_target = wt;
      wr_data   = wd;
    end
    tick(1);
    start = 1'b0;
    chk("done_cleared", done, 0);
    chk("busy_on_start", busy, 1);
    if (mode == 1) begin
      tick(iss0 + 5 - cyc);
      start     = 1'b1;
      wr_req    = 1'b1;
      wr_target = 1'($urandom);
      tick(1);
      start  = 1'b0;
      wr_req = 1'b0;
    end
    if (mode == 2) begin
      tick(iss + 5 - cyc);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_tbl_addr", tbl_addr, 0);
      chk("rst_sends", {send_adc, send_pll, wr_ack}, 0);
      chk("rst_data_adc", data_adc, 0);
      chk("rst_data_pll", data_pll, 0);
      chk("rst_pending", exp_q.size(), 0);
      m_adc  = '0;
      m_pll  = '0;
      m_done = 1'b0;
      return;
    end
    wait_idle();
    chk("seq_idle_cycle", cyc, fin);
    chk("seq_done", done, 1);
    m_done = 1'b1;
    if (mode == 3) begin
      tick(1);
      wr_req = 1'b0;
      wait_idle();
      chk("held_wr_idle_cycle", cyc, fin + 1 + 1 + XC + GC);
      chk("held_wr_done", done, 1);
    end
  endtask

  task automatic manual(input logic tgt, input logic [23:0] d);
    int w;
    w = cyc;
    ack_q.push_back(w);
    push_ev(tgt, d, w + 1);
    wr_req    = 1'b1;
    wr_target = tgt;
    wr_data   = d;
    tick(1);
    wr_req = 1'b0;
    chk("manual_busy", busy, 1);
    wait_idle();
    chk("manual_idle_cycle", cyc, w + 1 + 1 + XC + GC);
    chk("manual_done", done, m_done);
  endtask

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = '0;
    rst       = 1'b1;
    start     = 1'b0;
    wr_req    = 1'b0;
    wr_target = 1'b0;
    wr_data   = '0;
    tick(3);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_tbl_addr", tbl_addr, 0);
    chk("reset_pulses", {send_adc, send_pll, wr_ack}, 0);
    chk("reset_data", {data_adc, data_pll}, 0);
    rst = 1'b0;
    tick(2);

    mem[0] = {2'b00, 24'h000123};
    mem[1] = {2'b10, 24'hABCDEF};
    mem[2] = {2'b00, 24'h00FF00};
    run_table(0, 1'b0);
    tick(3);
    mem[1] = {2'b11, 24'hABCDEF};
    run_table(0, 1'b0);
    tick(2);
    manual(1'b1, 24'h5A5A5A);
    tick(2);
    run_table(3, 1'b1);
    tick(2);
    run_table(1, 1'b1);
    tick(2);
    run_table(2, 1'b1);
    tick(2);
    run_table(0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(int'($urandom_range(1, 4)));
      run_table(0, 1'b1);
      tick(int'($urandom_range(1, 4)));
      manual(1'($urandom), 24'($urandom));
    end
    tick(5);
    chk("events_drained", exp_q.size(), 0);
    chk("acks_drained", ack_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
